// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Detects load-use hazards combinationally and inserts one bubble per hazard.
// A small FSM freezes the whole pipeline while a multi-cycle data-memory
// access completes. A saturating counter records every cycle with the PC held.
module hazard_ctrl #(
    parameter int MEM_LATENCY = 3,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             mem_access_i,
    input  logic             branch_taken_i,
    output logic             select_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             id_ex_write_o,
    output logic             if_flush_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wait counter width: enough to hold MEM_LATENCY-2, never narrower than one bit.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          hazard;
    logic          freeze;

    // Load-use detection: the load in EX writes a register the ID instruction reads.
    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    assign hazard = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // State register and wait counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and the Mealy freeze output.
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        freeze    = 1'b0;
        unique case (state)
            ST_RUN: begin
                // Single-cycle memory never freezes; the FSM stays in RUN.
                if ((MEM_LATENCY > 1) && mem_access_i) begin
                    freeze = 1'b1;
                    if (MEM_LATENCY >= 3) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CW'(MEM_LATENCY - 2);
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                freeze  = 1'b1;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Release cycle: the access completes. mem_access_i is still high
                // for the held access, so it is deliberately ignored here.
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Pipeline controls. Freeze outranks the bubble, the bubble outranks the flush;
    // reset forces the idle (free-running, no bubble, no flush) values.
    always_comb begin
        select_o      = rst_i && hazard && !freeze;
        pc_write_o    = !rst_i || !(hazard || freeze);
        if_id_write_o = !rst_i || !(hazard || freeze);
        id_ex_write_o = !rst_i || !freeze;
        if_flush_o    = rst_i && branch_taken_i && !hazard && !freeze;
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (!pc_write_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Three instances share the stimulus:
// u0 MEM_LATENCY=3/CNT_W=16, u1 MEM_LATENCY=1, u2 MEM_LATENCY=3/CNT_W=2.
// The driver pushes hand-computed expectations; the monitor pops and compares.
module tb_hazard_ctrl;

    // Output vector order: {select, pc_write, if_id_write, id_ex_write, if_flush}
    localparam logic [4:0] IDLE  = 5'b01110;
    localparam logic [4:0] HAZ   = 5'b10010;
    localparam logic [4:0] FRZ   = 5'b00000;
    localparam logic [4:0] FLUSH = 5'b01111;

    typedef struct {
        string      name;
        int         unit;
        logic [4:0] o;
        int         c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_memread = 1'b0, mem_access = 1'b0, branch_taken = 1'b0;

    logic        sel [3];
    logic        pcw [3];
    logic        ifw [3];
    logic        exw [3];
    logic        flu [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    exp_t q[$];
    event cmp_ev;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_LATENCY(3), .CNT_W(16)) u0 (
        .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .mem_access_i(mem_access), .branch_taken_i(branch_taken),
        .select_o(sel[0]), .pc_write_o(pcw[0]), .if_id_write_o(ifw[0]),
        .id_ex_write_o(exw[0]), .if_flush_o(flu[0]), .stall_cnt_o(cnt0)
    );

    hazard_ctrl #(.MEM_LATENCY(1), .CNT_W(16)) u1 (
        .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .mem_access_i(mem_access), .branch_taken_i(branch_taken),
        .select_o(sel[1]), .pc_write_o(pcw[1]), .if_id_write_o(ifw[1]),
        .id_ex_write_o(exw[1]), .if_flush_o(flu[1]), .stall_cnt_o(cnt1)
    );

    hazard_ctrl #(.MEM_LATENCY(3), .CNT_W(2)) u2 (
        .clk_i(clk), .rst_i(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_uses_rt_i(id_uses_rt), .ex_memread_i(ex_memread), .ex_rt_i(ex_rt),
        .mem_access_i(mem_access), .branch_taken_i(branch_taken),
        .select_o(sel[2]), .pc_write_o(pcw[2]), .if_id_write_o(ifw[2]),
        .id_ex_write_o(exw[2]), .if_flush_o(flu[2]), .stall_cnt_o(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: after each driver strobe, compare every pending expectation.
    initial begin
        forever begin
            @(cmp_ev);
            #1;
            while (q.size() > 0) begin
                exp_t        e;
                logic [4:0]  act_o;
                logic [31:0] act_c;
                e     = q.pop_front();
                act_o = {sel[e.unit], pcw[e.unit], ifw[e.unit], exw[e.unit], flu[e.unit]};
                case (e.unit)
                    0:       act_c = 32'(cnt0);
                    1:       act_c = 32'(cnt1);
                    default: act_c = 32'(cnt2);
                endcase
                check({e.name, "/outs"}, 32'(act_o), 32'(e.o));
                check({e.name, "/stall_cnt"}, act_c, 32'(e.c));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                          input logic [4:0] irt, input logic urt, input logic ma,
                          input logic br);
        ex_memread   = mr;
        ex_rt        = rt;
        id_rs        = rs;
        id_rt        = irt;
        id_uses_rt   = urt;
        mem_access   = ma;
        branch_taken = br;
    endtask

    task automatic expect_u(input string name, input int unit, input logic [4:0] o, input int c);
        exp_t e;
        e.name = name;
        e.unit = unit;
        e.o    = o;
        e.c    = c;
        q.push_back(e);
    endtask

    task automatic strobe();
        -> cmp_ev;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every hazard input active: idle values on all instances.
        set_in(1, 5, 5, 0, 0, 1, 1);
        cyc();
        expect_u("rst_u0", 0, IDLE, 0);
        expect_u("rst_u1", 1, IDLE, 0);
        expect_u("rst_u2", 2, IDLE, 0);
        strobe();
        cyc();
        expect_u("rst_edge", 0, IDLE, 0);
        strobe();
        cyc();
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        expect_u("rst_release", 0, IDLE, 0);
        strobe();

        // Load-use hazards and flushes.
        cyc(); set_in(1, 5, 5, 0, 0, 0, 0); expect_u("lu_rs", 0, HAZ, 0);
        expect_u("lu_rs_u1", 1, HAZ, 0); strobe();
        cyc(); set_in(0, 5, 5, 0, 0, 0, 0); expect_u("lu_bubble", 0, IDLE, 1); strobe();
        cyc(); set_in(1, 0, 0, 0, 0, 0, 0); expect_u("lu_r0", 0, IDLE, 1); strobe();
        cyc(); set_in(1, 7, 3, 7, 0, 0, 0); expect_u("lu_rt_unused", 0, IDLE, 1); strobe();
        cyc(); set_in(1, 7, 3, 7, 1, 0, 0); expect_u("lu_rt", 0, HAZ, 1); strobe();
        cyc(); set_in(0, 0, 0, 0, 0, 0, 1); expect_u("flush", 0, FLUSH, 2); strobe();
        cyc(); set_in(1, 9, 9, 0, 0, 0, 1); expect_u("haz_over_flush", 0, HAZ, 2); strobe();
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0); expect_u("lu_after", 0, IDLE, 3); strobe();

        // Memory freeze, latency 3, then a back-to-back access.
        do_reset();
        cyc(); set_in(0, 0, 0, 0, 0, 1, 0); expect_u("frz_t0", 0, FRZ, 0);
        expect_u("frz_t0_lat1", 1, IDLE, 0); strobe();
        cyc(); expect_u("frz_t1", 0, FRZ, 1); expect_u("frz_t1_lat1", 1, IDLE, 0); strobe();
        cyc(); expect_u("frz_done", 0, IDLE, 2); strobe();
        cyc(); expect_u("frz_b2b_t0", 0, FRZ, 2); strobe();
        cyc(); expect_u("frz_b2b_t1", 0, FRZ, 3); strobe();
        cyc(); expect_u("frz_b2b_done", 0, IDLE, 4); strobe();
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0); expect_u("frz_idle", 0, IDLE, 4);
        expect_u("frz_idle_lat1", 1, IDLE, 0); strobe();

        // Freeze with a load-use hazard and a taken branch held together.
        do_reset();
        cyc(); set_in(1, 5, 5, 0, 0, 1, 1); expect_u("mix_t0", 0, FRZ, 0);
        expect_u("mix_t0_lat1", 1, HAZ, 0); strobe();
        cyc(); expect_u("mix_t1", 0, FRZ, 1); strobe();
        cyc(); expect_u("mix_done", 0, HAZ, 2); strobe();
        cyc(); set_in(0, 0, 0, 0, 0, 0, 1); expect_u("mix_flush", 0, FLUSH, 3); strobe();
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0); expect_u("mix_idle", 0, IDLE, 3); strobe();

        // Reset asserted during WAIT.
        do_reset();
        cyc(); set_in(0, 0, 0, 0, 0, 1, 0); expect_u("rw_t0", 0, FRZ, 0); strobe();
        cyc(); expect_u("rw_wait", 0, FRZ, 1); strobe();
        #5;
        rst_n = 1'b0;
        expect_u("rw_async", 0, IDLE, 0); strobe();
        cyc(); expect_u("rw_held", 0, IDLE, 0); strobe();
        cyc(); rst_n = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0);
        expect_u("rw_release", 0, IDLE, 0); strobe();
        cyc(); expect_u("rw_no_freeze", 0, IDLE, 0); strobe();

        // Saturation on the 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc();
            set_in(1, 5, 5, 0, 0, 0, 0);
            expect_u($sformatf("sat_%0d", i), 2, HAZ, (i < 3) ? i : 3);
            strobe();
        end
        cyc(); set_in(0, 0, 0, 0, 0, 0, 0); expect_u("sat_hold", 2, IDLE, 3);
        expect_u("sat_wide", 0, IDLE, 5); strobe();
        cyc(); expect_u("sat_hold2", 2, IDLE, 3); strobe();

        cyc();
        cyc();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It drives the bubble-select input of the ID-stage control mux. It also drives the PC, IF/ID and ID/EX write enables and the IF/ID flush. It detects load-use hazards combinationally and runs a small FSM that freezes the whole pipeline while a multi-cycle data-memory access completes.

## Interface
Parameters:
- MEM_LATENCY, default 3: data-memory access latency in cycles, ≥1. The pipeline freezes for MEM_LATENCY-1 cycles per access.
- CNT_W, default 16: width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_rs_i  in  5  rs of instruction in ID.
- id_rt_i  in  5  rt of instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- ex_memread_i  in  1  instruction in EX is a load.
- ex_rt_i  in  5  destination register of load in EX.
- mem_access_i  in  1  load/store present in MEM stage.
- branch_taken_i  in  1  branch in ID resolved taken.
- select_o  out  1  1 = zero the ID control bundle (insert bubble).
- pc_write_o  out  1  PC write enable.
- if_id_write_o  out  1  IF/ID write enable.
- id_ex_write_o  out  1  ID/EX write enable.
- if_flush_o  out  1  clear IF/ID on next edge.
- stall_cnt_o  out  CNT_W  saturating count of cycles with pc_write_o=0.

## Operation
- hazard = ex_memread_i & (ex_rt_i≠0) & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
- FSM states:
  - RUN: no freeze.
  - WAIT: freeze, count down.
  - DONE: release cycle; the memory access completes and the pipeline advances.
- Internal counter cnt has width ceil(log2(MEM_LATENCY)), minimum 1.
- freeze is a Mealy output:
  - 1 in RUN when mem_access_i & MEM_LATENCY>1.
  - 1 in WAIT.
  - 0 in DONE.
- Transitions:
  - RUN→WAIT: trigger with MEM_LATENCY≥3; cnt←MEM_LATENCY-2.
  - RUN→DONE: trigger with MEM_LATENCY==2.
  - WAIT: cnt←cnt-1; →DONE when cnt==1.
  - DONE→RUN unconditionally. mem_access_i is ignored in DONE, so the held access does not retrigger.
  - MEM_LATENCY==1: the FSM stays in RUN and freeze is always 0.
- Outputs:
  - select_o = hazard & ~freeze.
  - pc_write_o = if_id_write_o = ~(hazard | freeze).
  - id_ex_write_o = ~freeze.
  - if_flush_o = branch_taken_i & ~hazard & ~freeze.
- Priority: freeze > hazard > flush. During freeze no bubble or flush is issued; the held state is re-evaluated after release.
- stall_cnt_o increments on every edge where pc_write_o=0. It saturates at all-ones.

## Timing
- Reset (rst_i=0, asynchronous): state=RUN, cnt=0, stall_cnt_o=0.
  - While rst_i=0, outputs are forced to select_o=0, pc_write_o=1, if_id_write_o=1, id_ex_write_o=1, if_flush_o=0.
- Reset asserted mid-WAIT abandons the wait immediately; no freeze after deassertion unless retriggered.
- Hazard outputs are zero-latency combinational in the same cycle as the inputs.
- A load-use hazard yields exactly one bubble cycle. On the next edge the load moves to MEM and the bubble has ex_memread_i=0, so hazard clears.
- A memory access presented in cycle t freezes cycles t..t+MEM_LATENCY-2. Cycle t+MEM_LATENCY-1 is DONE with freeze=0.
- A hazard coinciding with a freeze is held (the ID/EX write is disabled) and produces its bubble in the DONE cycle.
- Back-to-back accesses: a new mem_access_i seen in the cycle after DONE (state RUN) retriggers.
- stall_cnt_o updates one edge after the stalled cycle.

## Test plan
- Reset: rst_i=0 with hazard inputs active → idle output values and stall_cnt_o=0; release → state RUN.
- Load-use on rs: ex_memread_i=1, ex_rt_i=5, id_rs_i=5 → select_o=1, pc_write_o=0, if_id_write_o=0 for 1 cycle; stall_cnt_o=1. Repeat with ex_rt_i=0 → no stall. Repeat with an rt match and id_uses_rt_i=0 → no stall.
- Memory freeze with MEM_LATENCY=3: mem_access_i held high from cycle t.
  - Required: id_ex_write_o=0 and pc_write_o=0 in cycles t and t+1; all writes =1 in t+2; stall_cnt_o=2.
  - Re-run with MEM_LATENCY=1 → no freeze.
- Freeze plus hazard plus taken branch together:
  - select_o=0 and if_flush_o=0 during the freeze.
  - In DONE: select_o=1 and if_flush_o=0.
- Reset asserted in WAIT: rst_i pulsed low → freeze drops immediately; stall_cnt_o=0.
- Saturation with CNT_W=2: 5 consecutive stall cycles → stall_cnt_o stays at 3.
